decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 204 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the incoming instruction feeding a
// 2-entry skid buffer so in_ready depends only on registered state.
module decode_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_inst,
   input  logic [31:0] in_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [2:0]  alu_op,
   output logic [6:0]  funct7,
   output logic [4:0]  shamt,
   output logic        is_r_type,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic [31:0] imm,
   output logic        use_imm,
   output logic        reg_write,
   output logic        illegal
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [2:0]  alu_op;
      logic [6:0]  funct7;
      logic [4:0]  shamt;
      logic        is_r_type;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        use_imm;
      logic        reg_write;
      logic        illegal;
   } dec_t;

   localparam dec_t RESET_ENTRY = '{pc: RESET_PC, default: '0};

   state_t state_q, state_d;
   dec_t   out_q, out_d, skid_q, skid_d, dec;
   logic   accept, rel;

   logic [6:0]  opcode, f7;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        f7_ok;

   assign opcode = in_inst[6:0];
   assign f3     = in_inst[14:12];
   assign f7     = in_inst[31:25];
   assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
   assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
   assign imm_u  = {in_inst[31:12], 12'h000};
   assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
   // 0100000 is only a valid modifier for SUB and SRA/SRAI
   assign f7_ok  = (f7 == 7'b0000000) ||
                   ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));

   always_comb begin
      dec       = '0;
      dec.pc    = in_pc;
      dec.shamt = in_inst[24:20];
      dec.rs1   = in_inst[19:15];
      dec.rs2   = in_inst[24:20];
      dec.rd    = in_inst[11:7];
      unique case (opcode)
         OPC_OP: begin
            dec.alu_op    = f3;
            dec.funct7    = f7;
            dec.is_r_type = 1'b1;
            dec.reg_write = 1'b1;
            dec.illegal   = !f7_ok;
         end
         OPC_OPIMM: begin
            dec.alu_op    = f3;
            dec.imm       = imm_i;
            dec.use_imm   = 1'b1;
            dec.reg_write = 1'b1;
            if ((f3 == 3'b001) || (f3 == 3'b101)) begin
               dec.funct7  = f7;
               dec.illegal = !f7_ok;
            end
         end
         OPC_LOAD: begin
            dec.imm       = imm_i;
            dec.use_imm   = 1'b1;
            dec.reg_write = 1'b1;
         end
         OPC_STORE: begin
            dec.imm     = imm_s;
            dec.use_imm = 1'b1;
         end
         OPC_BRANCH: begin
            dec.imm = imm_b;
            unique case (f3[2:1])
               2'b00:   dec.alu_op = 3'b100;
               2'b10:   dec.alu_op = 3'b010;
               2'b11:   dec.alu_op = 3'b011;
               default: dec.illegal = 1'b1;
            endcase
         end
         OPC_LUI, OPC_AUIPC: begin
            dec.imm       = imm_u;
            dec.use_imm   = 1'b1;
            dec.reg_write = 1'b1;
         end
         OPC_JAL: begin
            dec.imm       = imm_j;
            dec.use_imm   = 1'b1;
            dec.reg_write = 1'b1;
         end
         OPC_JALR: begin
            dec.imm       = imm_i;
            dec.use_imm   = 1'b1;
            dec.reg_write = 1'b1;
            dec.illegal   = (f3 != 3'b000);
         end
         default: dec.illegal = 1'b1;
      endcase
      if (dec.illegal) dec.reg_write = 1'b0;
   end

   assign in_ready  = (state_q != S_TWO);
   assign out_valid = (state_q != S_EMPTY);
   assign accept    = in_valid & in_ready;
   assign rel       = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = S_EMPTY;
      end else begin
         unique case (state_q)
            S_EMPTY: if (accept) begin
               out_d   = dec;
               state_d = S_ONE;
            end
            S_ONE: begin
               if (accept && rel) begin
                  out_d = dec;
               end else if (accept) begin
                  skid_d  = dec;
                  state_d = S_TWO;
               end else if (rel) begin
                  state_d = S_EMPTY;
               end
            end
            S_TWO: if (rel) begin
               out_d   = skid_q;
               state_d = S_ONE;
            end
            default: state_d = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_EMPTY;
         out_q   <= RESET_ENTRY;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         skid_q  <= skid_d;
      end
   end

   assign out_pc    = (state_q == S_EMPTY) ? RESET_PC : out_q.pc;
   assign alu_op    = out_q.alu_op;
   assign funct7    = out_q.funct7;
   assign shamt     = out_q.shamt;
   assign is_r_type = out_q.is_r_type;
   assign rs1       = out_q.rs1;
   assign rs2       = out_q.rs2;
   assign rd        = out_q.rd;
   assign imm       = out_q.imm;
   assign use_imm   = out_q.use_imm;
   assign reg_write = out_q.reg_write;
   assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, skid buffering, flush and async reset.
module tb_decode_stage;

   localparam logic [31:0] RST_PC = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_inst, in_pc, out_pc, imm;
   logic [2:0]  alu_op;
   logic [6:0]  funct7;
   logic [4:0]  shamt, rs1, rs2, rd;
   logic        is_r_type, use_imm, reg_write, illegal;

   int total = 0;
   int bad   = 0;

   decode_stage #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .alu_op(alu_op), .funct7(funct7), .shamt(shamt), .is_r_type(is_r_type),
      .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .use_imm(use_imm),
      .reg_write(reg_write), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
      in_valid = v;
      in_inst  = inst;
      in_pc    = pc;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      #12;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
      chk("rst_out_pc",    out_pc, RST_PC);
      chk("rst_imm",       imm, 32'd0);
      chk("rst_reg_write", {31'b0, reg_write}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // SUB x3,x1,x2
      out_ready = 1'b1;
      drive(1'b1, 32'h4020_81B3, 32'h100);
      tick();
      chk("sub_valid",   {31'b0, out_valid}, 32'd1);
      chk("sub_alu_op",  {29'b0, alu_op}, 32'd0);
      chk("sub_funct7",  {25'b0, funct7}, 32'h20);
      chk("sub_is_r",    {31'b0, is_r_type}, 32'd1);
      chk("sub_rd",      {27'b0, rd}, 32'd3);
      chk("sub_rs1",     {27'b0, rs1}, 32'd1);
      chk("sub_rs2",     {27'b0, rs2}, 32'd2);
      chk("sub_regw",    {31'b0, reg_write}, 32'd1);
      chk("sub_pc",      out_pc, 32'h100);
      chk("sub_imm",     imm, 32'd0);
      chk("sub_use_imm", {31'b0, use_imm}, 32'd0);
      chk("sub_illegal", {31'b0, illegal}, 32'd0);

      // SRAI x1,x1,3
      drive(1'b1, 32'h4030_D093, 32'h104);
      tick();
      chk("srai_alu_op",  {29'b0, alu_op}, 32'd5);
      chk("srai_funct7",  {25'b0, funct7}, 32'h20);
      chk("srai_shamt",   {27'b0, shamt}, 32'd3);
      chk("srai_is_r",    {31'b0, is_r_type}, 32'd0);
      chk("srai_use_imm", {31'b0, use_imm}, 32'd1);
      chk("srai_imm",     imm, 32'h0000_0403);
      chk("srai_pc",      out_pc, 32'h104);

      drive(1'b1, 32'hFFFF_FFFF, 32'h108);
      tick();
      chk("ill_valid",   {31'b0, out_valid}, 32'd1);
      chk("ill_illegal", {31'b0, illegal}, 32'd1);
      chk("ill_regw",    {31'b0, reg_write}, 32'd0);

      // BLTU x1,x2,-8
      drive(1'b1, 32'hFE20_ECE3, 32'h10C);
      tick();
      chk("bltu_alu_op",  {29'b0, alu_op}, 32'd3);
      chk("bltu_imm",     imm, 32'hFFFF_FFF8);
      chk("bltu_regw",    {31'b0, reg_write}, 32'd0);
      chk("bltu_funct7",  {25'b0, funct7}, 32'd0);
      chk("bltu_illegal", {31'b0, illegal}, 32'd0);

      // JALR with funct3=001
      drive(1'b1, 32'h0000_1067, 32'h110);
      tick();
      chk("jalr_illegal", {31'b0, illegal}, 32'd1);
      chk("jalr_regw",    {31'b0, reg_write}, 32'd0);

      // LUI x0,0x12345
      drive(1'b1, 32'h1234_5037, 32'h114);
      tick();
      chk("lui_imm",    imm, 32'h1234_5000);
      chk("lui_alu_op", {29'b0, alu_op}, 32'd0);
      chk("lui_regw",   {31'b0, reg_write}, 32'd1);

      drive(1'b0, 32'h0, 32'h0);
      tick();
      chk("drain_valid", {31'b0, out_valid}, 32'd0);
      chk("drain_pc",    out_pc, RST_PC);
      chk("drain_ready", {31'b0, in_ready}, 32'd1);

      // skid buffer: three back-to-back ADDIs with the consumer stalled
      out_ready = 1'b0;
      drive(1'b1, 32'h0010_0093, 32'h200);
      tick();
      chk("skid1_ready", {31'b0, in_ready}, 32'd1);
      chk("skid1_pc",    out_pc, 32'h200);
      drive(1'b1, 32'h0020_0093, 32'h204);
      tick();
      chk("skid2_ready", {31'b0, in_ready}, 32'd0);
      chk("skid2_pc",    out_pc, 32'h200);
      drive(1'b1, 32'h0030_0093, 32'h208);
      tick();
      chk("skid3_ready", {31'b0, in_ready}, 32'd0);
      chk("skid3_pc",    out_pc, 32'h200);
      chk("skid3_imm",   imm, 32'd1);
      out_ready = 1'b1;
      tick();
      chk("skid4_valid", {31'b0, out_valid}, 32'd1);
      chk("skid4_pc",    out_pc, 32'h204);
      chk("skid4_imm",   imm, 32'd2);
      chk("skid4_ready", {31'b0, in_ready}, 32'd1);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      chk("skid5_valid", {31'b0, out_valid}, 32'd1);
      chk("skid5_pc",    out_pc, 32'h208);
      chk("skid5_imm",   imm, 32'd3);
      tick();
      chk("skid6_valid", {31'b0, out_valid}, 32'd0);

      // flush while full, with an instruction offered
      out_ready = 1'b0;
      drive(1'b1, 32'h0010_0093, 32'h300);
      tick();
      drive(1'b1, 32'h0020_0093, 32'h304);
      tick();
      chk("fl_full_ready", {31'b0, in_ready}, 32'd0);
      drive(1'b1, 32'h0040_0093, 32'h30C);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      chk("fl_two_valid", {31'b0, out_valid}, 32'd0);
      chk("fl_two_ready", {31'b0, in_ready}, 32'd1);
      tick();
      chk("fl_two_after", {31'b0, out_valid}, 32'd0);

      // flush in ONE discards the same-cycle accept
      drive(1'b1, 32'h0050_0093, 32'h310);
      tick();
      chk("fl_one_pre", {31'b0, out_valid}, 32'd1);
      drive(1'b1, 32'h0060_0093, 32'h314);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_one_valid", {31'b0, out_valid}, 32'd0);
      out_ready = 1'b1;
      drive(1'b1, 32'h0070_0093, 32'h400);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      chk("fl_new_pc",  out_pc, 32'h400);
      chk("fl_new_imm", imm, 32'd7);
      tick();
      chk("fl_new_drain", {31'b0, out_valid}, 32'd0);

      // async reset while holding one instruction
      out_ready = 1'b0;
      drive(1'b1, 32'h0080_0093, 32'h500);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      chk("ar_pre_valid", {31'b0, out_valid}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("ar_valid", {31'b0, out_valid}, 32'd0);
      chk("ar_ready", {31'b0, in_ready}, 32'd1);
      chk("ar_pc",    out_pc, RST_PC);
      chk("ar_imm",   imm, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("ar_post1", {31'b0, out_valid}, 32'd0);
      tick();
      chk("ar_post2", {31'b0, out_valid}, 32'd0);
      drive(1'b1, 32'h0090_0093, 32'h600);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      chk("ar_new_pc",  out_pc, 32'h600);
      chk("ar_new_imm", imm, 32'd9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
